// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner with per-frame digit snapshot.
// Optional leading-zero blanking above DP_DIGIT when SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned DP_DIGIT    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] reg_d0,
   input  logic [3:0] reg_d1,
   input  logic [3:0] reg_d2,
   input  logic [3:0] reg_d3,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

   logic [CntW-1:0] cnt;
   logic [1:0]      idx;
   logic [3:0]      snap [4];
   logic [3:0]      eff  [4];
   logic [3:0]      src_digit;
   logic            frame_start;
   logic            terminal;
   logic            blank;
   logic [3:0]      an_d;
   logic [6:0]      seg_d;
   logic            dp_d;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign frame_start = (cnt == '0) && (idx == 2'd0);
   assign terminal    = (cnt == CntMax);

   always_comb begin
      // On the frame-start cycle the snapshot is still stale, so use the live inputs
      eff[0] = frame_start ? reg_d0 : snap[0];
      eff[1] = frame_start ? reg_d1 : snap[1];
      eff[2] = frame_start ? reg_d2 : snap[2];
      eff[3] = frame_start ? reg_d3 : snap[3];
      src_digit = eff[idx];
      blank = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
      if (int'(idx) > int'(DP_DIGIT)) begin
         blank = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (k >= int'(idx) && eff[k] != 4'd0) blank = 1'b0;
         end
      end
`endif
      seg_d = blank ? 7'h7F : decode(src_digit);
      an_d  = ~(4'b0001 << idx);
      dp_d  = (int'(idx) == int'(DP_DIGIT)) ? 1'b0 : 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         idx <= 2'd0;
         for (int k = 0; k < 4; k++) snap[k] <= 4'd0;
         an  <= 4'b1111;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         cnt <= terminal ? '0 : cnt + CntW'(1);
         if (terminal) idx <= idx + 2'd1;
         if (frame_start) begin
            snap[0] <= reg_d0;
            snap[1] <= reg_d1;
            snap[2] <= reg_d2;
            snap[3] <= reg_d3;
         end
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: stimulus pushes expected {an,seg,dp} per edge,
// a negedge monitor pops and compares. Honours SEVEN_SEG_LZB_EN for the blanking frame.
module tb_seven_seg_scan;

   localparam int unsigned RDIV = 4;
   localparam int unsigned DPD  = 2;

   logic       clock;
   logic       reset;
   logic [3:0] reg_d0, reg_d1, reg_d2, reg_d3;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   logic [11:0] exp_q [$];
   int          n_checks;
   int          n_errors;

   seven_seg_scan #(
      .REFRESH_DIV(RDIV),
      .DP_DIGIT   (DPD)
   ) dut (
      .clock (clock),
      .reset (reset),
      .reg_d0(reg_d0),
      .reg_d1(reg_d1),
      .reg_d2(reg_d2),
      .reg_d3(reg_d3),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: outputs are registered, so they are stable at the falling edge
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         logic [11:0] e;
         e = exp_q.pop_front();
         check("an",  {3'b0, an},  {3'b0, e[11:8]});
         check("seg", seg,         e[7:1]);
         check("dp",  {6'b0, dp},  {6'b0, e[0]});
      end
   end

   task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
      exp_q.push_back({a, s, d});
   endtask

   task automatic cycle(input logic [3:0] a, input logic [6:0] s, input logic d);
      @(posedge clock);
      #1;
      push(a, s, d);
   endtask

   task automatic digit(input int k, input logic [6:0] s);
      logic [3:0] a;
      a = ~(4'b0001 << k);
      for (int i = 0; i < int'(RDIV); i++) cycle(a, s, (k == int'(DPD)) ? 1'b0 : 1'b1);
   endtask

   task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d);
      reg_d0 = a;
      reg_d1 = b;
      reg_d2 = c;
      reg_d3 = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      set_in(4'd1, 4'd2, 4'd3, 4'd4);

      // Reset held: outputs at reset values
      cycle(4'b1111, 7'h7F, 1'b1);
      cycle(4'b1111, 7'h7F, 1'b1);
      reset = 1'b0;

      // Frame A: full scan of 1,2,3,4
      digit(0, 7'h79);
      digit(1, 7'h24);
      digit(2, 7'h30);
      digit(3, 7'h19);

      // Frame B: d0 changes mid-frame, must stay hidden until next frame
      digit(0, 7'h79);
      cycle(4'b1101, 7'h24, 1'b1);
      reg_d0 = 4'd9;
      cycle(4'b1101, 7'h24, 1'b1);
      cycle(4'b1101, 7'h24, 1'b1);
      cycle(4'b1101, 7'h24, 1'b1);
      digit(2, 7'h30);
      digit(3, 7'h19);
      // Now in the frame-start cycle: this change must be captured
      reg_d2 = 4'hC;

      // Frame C: 9 shows, non-BCD digit 2 shows a dash with dp lit
      digit(0, 7'h10);
      digit(1, 7'h24);
      digit(2, 7'h3F);
      digit(3, 7'h19);
      set_in(4'd5, 4'd0, 4'd0, 4'd0);

      // Frame D: leading zeros
      digit(0, 7'h12);
      digit(1, 7'h40);
      digit(2, 7'h40);
`ifdef SEVEN_SEG_LZB_EN
      digit(3, 7'h7F);
`else
      digit(3, 7'h40);
`endif
      set_in(4'd1, 4'd2, 4'd3, 4'd4);

      // Frame E: reset asserted while digit 2 is enabled
      digit(0, 7'h79);
      digit(1, 7'h24);
      cycle(4'b1011, 7'h30, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      push(4'b1111, 7'h7F, 1'b1);
      set_in(4'd7, 4'd8, 4'd6, 4'd4);
      cycle(4'b1111, 7'h7F, 1'b1);
      cycle(4'b1111, 7'h7F, 1'b1);
      reset = 1'b0;

      // Frame F: restart at digit 0 with a fresh snapshot
      digit(0, 7'h78);
      digit(1, 7'h00);
      digit(2, 7'h02);
      digit(3, 7'h19);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
      #1;
      if (exp_q.size() > 0) begin
         n_errors++;
         $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
